// File: rtl/fir_coef_bank_if.sv
// Bus-side port bundle of the FIR coefficient bank: strobes, address, data and
// the registered read/error responses.
interface fir_coef_bank_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             i_wr_en;
  logic             i_rd_en;
  logic [AW-1:0]    i_addr;
  logic [WIDTH-1:0] i_write_data;
  logic [WIDTH-1:0] o_read_data;
  logic             o_rd_valid;
  logic             o_wr_err;

  modport master (
    output i_wr_en, i_rd_en, i_addr, i_write_data,
    input  o_read_data, o_rd_valid, o_wr_err
  );

  modport slave (
    input  i_wr_en, i_rd_en, i_addr, i_write_data,
    output o_read_data, o_rd_valid, o_wr_err
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered multi-channel FIR coefficient store: the bus edits a shadow bank,
// and a committed shadow set is copied atomically into the active bank on a sample tick.
module fir_coef_bank #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TAPS     = 16,
  parameter int unsigned CHANNELS = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  fir_coef_bank_if.slave   bus,
  input  logic             i_bypass,
  input  logic             i_commit,
  input  logic             i_sample_tick,
  output logic             o_pending,
  output logic             o_swapped,
  output logic [WIDTH-1:0] o_coef [CHANNELS][TAPS]
);

  localparam int unsigned NWords = CHANNELS * TAPS;
  localparam int unsigned AW     = $clog2(NWords);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e           state_q, state_d;
  logic             swap_en;
  logic             wr_ok;
  logic             in_range;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] shadow_q [NWords];
  logic [WIDTH-1:0] active_q [NWords];

  assign addr = bus.i_addr;

  // With a power-of-two word count every encodable address is legal.
  if (NWords == (2 ** AW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (addr < AW'(NWords));
  end

  // Writes are frozen while a swap is armed so the committed set cannot change.
  assign wr_ok = bus.i_wr_en & (state_q == StIdle) & in_range;

  always_comb begin
    state_d = state_q;
    swap_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_commit) state_d = StPending;
      end
      StPending: begin
        if (i_sample_tick) begin
          state_d = StIdle;
          swap_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= StIdle;
      o_swapped       <= 1'b0;
      bus.o_wr_err    <= 1'b0;
      bus.o_rd_valid  <= 1'b0;
      bus.o_read_data <= '0;
    end else begin
      state_q        <= state_d;
      o_swapped      <= swap_en;
      bus.o_wr_err   <= bus.i_wr_en & ~wr_ok;
      bus.o_rd_valid <= bus.i_rd_en;
      // Reads sample the pre-edge shadow, so a same-cycle write is not visible.
      if (bus.i_rd_en) begin
        bus.o_read_data <= in_range ? shadow_q[addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NWords; i++) shadow_q[i] <= '0;
    end else if (wr_ok) begin
      shadow_q[addr] <= bus.i_write_data;
    end
  end

  // Swap and bypass write never coincide: swaps happen only while writes are frozen.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NWords; i++) active_q[i] <= '0;
    end else if (swap_en) begin
      for (int i = 0; i < NWords; i++) active_q[i] <= shadow_q[i];
    end else if (wr_ok && i_bypass) begin
      active_q[addr] <= bus.i_write_data;
    end
  end

  assign o_pending = (state_q == StPending);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign o_coef[c][t] = active_q[c*TAPS + t];
    end
  end

endmodule
